// File: rtl/debug_view_pkg.sv
// Shared mode encodings and width helpers for the LED debug viewer.
package debug_view_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_SCROLL = 2'd1;
  localparam logic [1:0] MODE_FLAGS  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max1(input int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
module button_debounce
  import debug_view_pkg::*;
#(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CntW = max1(clog2(DEB_CYC));

  logic            r_sync1;
  logic            r_sync2;
  logic [1:0]      r_valid;
  logic            r_level;
  logic            r_rise;
  logic            r_armed;
  logic [CntW-1:0] r_cnt;
  logic            w_accept;

  assign w_accept = (r_sync2 != r_level) && (r_cnt == CntW'(DEB_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_valid <= 2'b00;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_valid <= {r_valid[0], 1'b1};
      r_rise  <= w_accept && r_sync2 && r_armed;
      // A button held through reset must be seen released before it can press.
      if (r_valid[1] && !r_sync2 && !r_level) r_armed <= 1'b1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_rise;

endmodule

// File: rtl/led_debug_viewer.sv
// Board debug display: channel/slice mux with manual, auto-scroll and flag views plus freeze.
module led_debug_viewer
  import debug_view_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SCROLL_DIV = 50_000_000,
  parameter int unsigned DEB_CYC    = 1_000_000,
  localparam int unsigned NSLICE    = DATA_W / LED_W,
  localparam int unsigned CW        = max1(clog2(NUM_CH)),
  localparam int unsigned SW        = max1(clog2(NSLICE))
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH*DATA_W-1:0] CH_DATA,
  input  logic [LED_W-1:0]         FLAGS,
  input  logic [CW-1:0]            CH_SEL,
  input  logic [SW-1:0]            SLICE_SEL,
  input  logic [1:0]               MODE,
  input  logic                     FREEZE_BTN,
  output logic [LED_W-1:0]         LED,
  output logic [SW-1:0]            SLICE_IDX,
  output logic                     FROZEN
);

  localparam int unsigned PW = max1(clog2(SCROLL_DIV));

  logic [NUM_CH*DATA_W-1:0] r_snap_data;
  logic [LED_W-1:0]         r_snap_flags;
  logic                     r_frozen;
  logic [LED_W-1:0]         r_led;
  logic [SW-1:0]            r_idx;
  logic [PW-1:0]            r_presc;
  logic                     r_in_scroll;

  logic                     w_level;
  logic                     w_press;
  logic [NUM_CH*DATA_W-1:0] w_src;
  logic [LED_W-1:0]         w_src_flags;
  logic [DATA_W-1:0]        w_word;
  logic [LED_W-1:0]         w_slice;
  logic [LED_W-1:0]         w_led_d;
  logic [SW-1:0]            w_idx_d;
  logic [PW-1:0]            w_presc_d;
  logic                     w_scroll;
  logic                     w_entry;
  logic                     w_tick;

  button_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_freeze_btn (
    .CLK        (CLK),
    .RST        (RST),
    .btn_raw    (FREEZE_BTN),
    .level      (w_level),
    .rise_pulse (w_press)
  );

  assign w_scroll = (MODE == MODE_SCROLL);
  assign w_entry  = w_scroll && !r_in_scroll;
  assign w_tick   = w_scroll && r_in_scroll && (r_presc == PW'(SCROLL_DIV - 1));

  always_comb begin
    w_src       = r_frozen ? r_snap_data : CH_DATA;
    w_src_flags = r_frozen ? r_snap_flags : FLAGS;

    w_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_SEL == CW'(k)) w_word = w_src[k*DATA_W +: DATA_W];
    end

    case (MODE)
      MODE_SCROLL: begin
        if (w_entry)     w_idx_d = '0;
        else if (w_tick) w_idx_d = (r_idx == SW'(NSLICE - 1)) ? '0 : r_idx + SW'(1);
        else             w_idx_d = r_idx;
      end
      MODE_FLAGS:  w_idx_d = r_idx;
      default:     w_idx_d = (NSLICE > 1) ? SLICE_SEL : '0;
    endcase

    // Out-of-range slice numbers match no entry and display zero.
    w_slice = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (w_idx_d == SW'(s)) w_slice = w_word[s*LED_W +: LED_W];
    end

    w_led_d   = (MODE == MODE_FLAGS) ? w_src_flags : w_slice;
    w_presc_d = (!w_scroll || w_entry || w_tick) ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_snap_data  <= '0;
      r_snap_flags <= '0;
      r_frozen     <= 1'b0;
      r_led        <= '0;
      r_idx        <= '0;
      r_presc      <= '0;
      r_in_scroll  <= 1'b0;
    end else begin
      r_led       <= w_led_d;
      r_idx       <= w_idx_d;
      r_presc     <= w_presc_d;
      r_in_scroll <= w_scroll;
      if (w_press && w_level) begin
        if (!r_frozen) begin
          r_snap_data  <= CH_DATA;
          r_snap_flags <= FLAGS;
          r_frozen     <= 1'b1;
        end else begin
          r_frozen <= 1'b0;
        end
      end
    end
  end

  assign LED       = r_led;
  assign SLICE_IDX = r_idx;
  assign FROZEN    = r_frozen;

endmodule

// File: tb/tb_led_debug_viewer.sv
// Self-checking bench: directed vector table, scroll/freeze/reset sequences, random vs model.
module tb_led_debug_viewer;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LED_W      = 8;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned SCROLL_DIV = 4;
  localparam int unsigned DEB_CYC    = 3;
  localparam int unsigned NSLICE     = DATA_W / LED_W;

  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] CH_DATA;
  logic [7:0]   FLAGS;
  logic [1:0]   CH_SEL;
  logic [1:0]   SLICE_SEL;
  logic [1:0]   MODE;
  logic         FREEZE_BTN;
  logic [7:0]   LED;
  logic [1:0]   SLICE_IDX;
  logic         FROZEN;

  always #5 CLK = ~CLK;

  led_debug_viewer #(
    .DATA_W     (DATA_W),
    .LED_W      (LED_W),
    .NUM_CH     (NUM_CH),
    .SCROLL_DIV (SCROLL_DIV),
    .DEB_CYC    (DEB_CYC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CH_DATA    (CH_DATA),
    .FLAGS      (FLAGS),
    .CH_SEL     (CH_SEL),
    .SLICE_SEL  (SLICE_SEL),
    .MODE       (MODE),
    .FREEZE_BTN (FREEZE_BTN),
    .LED        (LED),
    .SLICE_IDX  (SLICE_IDX),
    .FROZEN     (FROZEN)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: display rules expressed as time-in-scroll and mismatch-run arithmetic.
  logic [127:0] m_snap;
  logic [7:0]   m_snapf;
  logic         m_frozen, m_in_scroll, m_s1, m_s2, m_level, m_press, m_armed;
  logic [7:0]   m_led;
  int           m_idx, m_n, m_run, m_since;

  task automatic model_step();
    logic [127:0] src, sh;
    logic [7:0]   srcf;
    logic         s2_pre, lvl_pre, armed_pre, new_press;
    if (!RST) begin
      m_snap = '0; m_snapf = '0; m_frozen = 0; m_in_scroll = 0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_armed = 0;
      m_led = 0; m_idx = 0; m_n = 0; m_run = 0; m_since = 0;
    end else begin
      src  = m_frozen ? m_snap : CH_DATA;
      srcf = m_frozen ? m_snapf : FLAGS;
      if (MODE == 2'd1) begin
        m_n   = m_in_scroll ? m_n + 1 : 0;
        m_idx = (m_n / SCROLL_DIV) % NSLICE;
      end else if (MODE != 2'd2) begin
        m_idx = int'(SLICE_SEL);
      end
      if (MODE == 2'd2) begin
        m_led = srcf;
      end else if (CH_SEL >= NUM_CH || m_idx >= NSLICE) begin
        m_led = 8'h00;
      end else begin
        sh    = src >> (int'(CH_SEL) * DATA_W + m_idx * LED_W);
        m_led = sh[7:0];
      end
      m_in_scroll = (MODE == 2'd1);
      if (m_press) begin
        if (!m_frozen) begin
          m_snap = CH_DATA; m_snapf = FLAGS; m_frozen = 1;
        end else begin
          m_frozen = 0;
        end
      end
      s2_pre = m_s2; lvl_pre = m_level; armed_pre = m_armed; new_press = 0;
      if (s2_pre != lvl_pre) begin
        m_run++;
        if (m_run == DEB_CYC) begin
          m_level = s2_pre; m_run = 0; new_press = s2_pre && armed_pre;
        end
      end else begin
        m_run = 0;
      end
      if (m_since >= 2 && !s2_pre && !lvl_pre) m_armed = 1;
      m_s2 = m_s1; m_s1 = FREEZE_BTN; m_press = new_press;
      if (m_since < 2) m_since++;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    CH_DATA[k*32 +: 32] = v;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] ch;
    logic [1:0] sl;
    logic [7:0] flags;
    logic [7:0] led;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 2'd1, 2'd2, 8'h00, 8'hAD, 2'd2};
    vecs[1] = '{2'd0, 2'd1, 2'd0, 8'h00, 8'hEF, 2'd0};
    vecs[2] = '{2'd0, 2'd1, 2'd3, 8'h00, 8'hDE, 2'd3};
    vecs[3] = '{2'd3, 2'd2, 2'd1, 8'h00, 8'hF0, 2'd1};
    vecs[4] = '{2'd0, 2'd3, 2'd3, 8'h00, 8'h01, 2'd3};
    vecs[5] = '{2'd2, 2'd3, 2'd3, 8'h02, 8'h02, 2'd3};
    vecs[6] = '{2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 2'd3};
    vecs[7] = '{2'd0, 2'd0, 2'd0, 8'h00, 8'h11, 2'd0};

    RST = 0; MODE = 2'd0; CH_SEL = 2'd1; SLICE_SEL = 2'd1; FLAGS = 8'hFF; FREEZE_BTN = 0;
    set_ch(0, 32'h44332211); set_ch(1, 32'hDEADBEEF);
    set_ch(2, 32'hCAFEF00D); set_ch(3, 32'h01234567);
    @(negedge CLK);
    tick(2);
    check("reset_led", LED, 8'h00);
    check("reset_idx", SLICE_IDX, 2'd0);
    check("reset_frozen", FROZEN, 1'b0);
    RST = 1;

    for (int i = 0; i < 8; i++) begin
      MODE = vecs[i].mode; CH_SEL = vecs[i].ch; SLICE_SEL = vecs[i].sl; FLAGS = vecs[i].flags;
      tick();
      check($sformatf("vec%0d_led", i), LED, vecs[i].led);
      check($sformatf("vec%0d_idx", i), SLICE_IDX, vecs[i].idx);
    end

    MODE = 2'd1; CH_SEL = 2'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("scroll%0d_led", i), LED, 8'(17 * (((i / 4) % 4) + 1)));
      check($sformatf("scroll%0d_idx", i), SLICE_IDX, 32'((i / 4) % 4));
    end

    MODE = 2'd0; CH_SEL = 2'd1; SLICE_SEL = 2'd2;
    tick();
    check("frz_view", LED, 8'hAD);
    FREEZE_BTN = 1; tick(); FREEZE_BTN = 0; tick(8);
    check("glitch_ignored", FROZEN, 1'b0);
    FREEZE_BTN = 1; tick(6);
    check("frz_set", FROZEN, 1'b1);
    set_ch(1, 32'h0); tick();
    check("frz_hold_led", LED, 8'hAD);
    FREEZE_BTN = 0; tick(8);
    check("frz_release_kept", FROZEN, 1'b1);
    check("frz_release_led", LED, 8'hAD);
    FREEZE_BTN = 1; tick(6);
    check("unfrz", FROZEN, 1'b0);
    tick();
    check("unfrz_led", LED, 8'h00);
    FREEZE_BTN = 0; tick(8);

    set_ch(1, 32'hDEADBEEF);
    FREEZE_BTN = 1; tick(6);
    check("mid_frozen", FROZEN, 1'b1);
    check("mid_idx", SLICE_IDX, 2'd2);
    RST = 0; tick(2);
    check("mid_rst_idx", SLICE_IDX, 2'd0);
    check("mid_rst_frozen", FROZEN, 1'b0);
    check("mid_rst_led", LED, 8'h00);
    RST = 1; tick(12);
    check("held_no_press", FROZEN, 1'b0);
    FREEZE_BTN = 0; tick(8);
    check("released_no_press", FROZEN, 1'b0);
    FREEZE_BTN = 1; tick(6);
    check("repress_frozen", FROZEN, 1'b1);
    FREEZE_BTN = 0; tick(8);

    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 1500; c++) begin
        RST = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 15) == 0) MODE = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) CH_SEL = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) SLICE_SEL = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) set_ch($urandom_range(0, 3), $urandom);
        FLAGS = 8'($urandom_range(0, 255));
        if (hold == 0) begin
          FREEZE_BTN = ~FREEZE_BTN;
          hold = $urandom_range(1, 10);
        end
        hold--;
        tick();
        check("rnd_led", LED, m_led);
        check("rnd_idx", SLICE_IDX, 32'(m_idx));
        check("rnd_frozen", FROZEN, m_frozen);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
